// File: rtl/controle_ciclo_pkg.sv
// State codes, rinse-count sizing and actuator decode shared by the washer sequencer.
// Compile with ENXAGUE_DUPLO_EN defined for two fill/rinse/drain rounds before spin.
package controle_pkg;

  localparam logic [2:0] OCIOSO      = 3'd0;
  localparam logic [2:0] ENCHER      = 3'd1;
  localparam logic [2:0] LAVAR       = 3'd2;
  localparam logic [2:0] DRENAR      = 3'd3;
  localparam logic [2:0] ENXAGUAR    = 3'd4;
  localparam logic [2:0] CENTRIFUGAR = 3'd5;
  localparam logic [2:0] PAUSA       = 3'd6;
  localparam logic [2:0] ERRO        = 3'd7;

`ifdef ENXAGUE_DUPLO_EN
  localparam int ENX_W = 2;
  localparam int N_ENX = 2;
`else
  localparam int ENX_W = 1;
  localparam int N_ENX = 1;
`endif

  typedef struct packed {
    logic valvula;
    logic bomba;
    logic motor_lavar;
    logic motor_centrifugar;
    logic trava;
    logic erro;
  } atuadores_t;

  function automatic logic ativo(input logic [2:0] est);
    return (est >= ENCHER) && (est <= CENTRIFUGAR);
  endfunction

  function automatic atuadores_t decodifica(input logic [2:0] est);
    atuadores_t a;
    a = '0;
    case (est)
      ENCHER:         begin a.valvula = 1'b1; a.trava = 1'b1; end
      LAVAR, ENXAGUAR: begin a.motor_lavar = 1'b1; a.trava = 1'b1; end
      DRENAR:         begin a.bomba = 1'b1; a.trava = 1'b1; end
      CENTRIFUGAR:    begin a.bomba = 1'b1; a.motor_centrifugar = 1'b1; a.trava = 1'b1; end
      ERRO:           a.erro = 1'b1;
      default:        a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/controle_ciclo_temporizador.sv
// Free-running phase timer: clear wins over enable, holds when neither is set.
module temporizador #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/controle_ciclo.sv
// Washing-cycle sequencer: fill/wash/drain/fill/rinse/drain/spin with pause and timeout error.
// ENXAGUE_DUPLO_EN (see controle_pkg) turns the rinse flag into a two-round counter.
module controle_ciclo
  import controle_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int T_LAVAR      = 1000,
  parameter int T_ENXAGUE    = 600,
  parameter int T_CENTRIF    = 800,
  parameter int T_ENCHER_MAX = 2000,
  parameter int T_DRENAR_MAX = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pulso_iniciar,
  input  logic       tampa_fechada,
  input  logic       nivel_cheio,
  input  logic       nivel_vazio,
  output logic       valvula_entrada,
  output logic       bomba_saida,
  output logic       motor_lavar,
  output logic       motor_centrifugar,
  output logic       trava_tampa,
  output logic       erro,
  output logic       fim_ciclo,
  output logic [2:0] estado
);

  localparam logic [CNT_W-1:0] L_LAVAR    = CNT_W'(T_LAVAR - 1);
  localparam logic [CNT_W-1:0] L_ENXAGUE  = CNT_W'(T_ENXAGUE - 1);
  localparam logic [CNT_W-1:0] L_CENTRIF  = CNT_W'(T_CENTRIF - 1);
  localparam logic [CNT_W-1:0] L_ENCHER   = CNT_W'(T_ENCHER_MAX - 1);
  localparam logic [CNT_W-1:0] L_DRENAR   = CNT_W'(T_DRENAR_MAX - 1);
  localparam logic [ENX_W-1:0] ENX_LIMITE = ENX_W'(N_ENX);

  logic [2:0]       r_estado, r_salvo, w_prox;
  logic [ENX_W-1:0] r_enx, w_enx_prox;
  logic             r_fim;
  logic [CNT_W-1:0] w_cnt;
  logic             w_pausar, w_clr, w_en;
  atuadores_t       w_at;

  temporizador #(.CNT_W(CNT_W)) u_tempo (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_clr),
    .i_enable (w_en),
    .o_count  (w_cnt)
  );

  // Pause requests outrank every sensor, expiry and timeout decision below.
  always_comb begin
    w_prox     = r_estado;
    w_enx_prox = r_enx;
    w_pausar   = ativo(r_estado) && (pulso_iniciar || !tampa_fechada);
    if (w_pausar) begin
      w_prox = PAUSA;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (pulso_iniciar && tampa_fechada) begin
            w_prox     = ENCHER;
            w_enx_prox = '0;
          end
        end
        ENCHER: begin
          if (nivel_cheio)            w_prox = (r_enx == '0) ? LAVAR : ENXAGUAR;
          else if (w_cnt == L_ENCHER) w_prox = ERRO;
        end
        LAVAR:       if (w_cnt == L_LAVAR)   w_prox = DRENAR;
        ENXAGUAR:    if (w_cnt == L_ENXAGUE) w_prox = DRENAR;
        DRENAR: begin
          if (nivel_vazio) begin
            if (r_enx < ENX_LIMITE) begin
              w_prox     = ENCHER;
              w_enx_prox = r_enx + 1'b1;
            end else begin
              w_prox = CENTRIFUGAR;
            end
          end else if (w_cnt == L_DRENAR) begin
            w_prox = ERRO;
          end
        end
        CENTRIFUGAR: if (w_cnt == L_CENTRIF) w_prox = OCIOSO;
        PAUSA:       if (pulso_iniciar && tampa_fechada) w_prox = r_salvo;
        ERRO: begin
          if (pulso_iniciar) begin
            w_prox     = OCIOSO;
            w_enx_prox = '0;
          end
        end
        default:     w_prox = OCIOSO;
      endcase
    end
  end

  // Entering or leaving PAUSA keeps the count so a resumed phase finishes its budget.
  assign w_clr = (w_prox != r_estado) && (w_prox != PAUSA) && (r_estado != PAUSA);
  assign w_en  = ativo(r_estado);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
      r_salvo  <= OCIOSO;
      r_enx    <= '0;
      r_fim    <= 1'b0;
    end else begin
      r_estado <= w_prox;
      r_enx    <= w_enx_prox;
      r_fim    <= (r_estado == CENTRIFUGAR) && (w_prox == OCIOSO);
      if (w_pausar) r_salvo <= r_estado;
    end
  end

  assign w_at              = decodifica(r_estado);
  assign valvula_entrada   = w_at.valvula;
  assign bomba_saida       = w_at.bomba;
  assign motor_lavar       = w_at.motor_lavar;
  assign motor_centrifugar = w_at.motor_centrifugar;
  assign trava_tampa       = w_at.trava;
  assign erro              = w_at.erro;
  assign fim_ciclo         = r_fim;
  assign estado            = r_estado;

endmodule
